// File: rtl/operand_sel_stage_pkg.sv
// Shared types and constants for the operand select stage.
package operand_sel_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam logic [7:0] BAD_CNT_MAX = 8'd255;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_sel_stage_comb.sv
// Flat-bus operand multiplexer; an out-of-range select yields operand 0.
module operand_sel_comb
    import operand_sel_stage_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [DATA_W-1:0]        sel_data
);

    always_comb begin
        sel_data = in_data[0 +: DATA_W];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand select stage: mux in front of a 2-entry skid buffer with bad-select tracking.
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | output register holds an entry
//   TWO   | output register and skid entry both full, input stalled
module operand_sel_stage
    import operand_sel_stage_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     bad_sel,
    output logic [7:0]               bad_sel_cnt
);

    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
    logic              in_ready_q, in_ready_d;
    logic              bad_sel_q, bad_sel_d;
    logic [7:0]        bad_cnt_q, bad_cnt_d;

    logic [DATA_W-1:0] sel_data;
    logic              in_xfer;
    logic              out_xfer;
    logic              sel_oob;

    operand_sel_comb #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .sel      (sel),
        .in_data  (in_data),
        .sel_data (sel_data)
    );

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_sel     = out_sel_q;
    assign bad_sel     = bad_sel_q;
    assign bad_sel_cnt = bad_cnt_q;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;
    assign sel_oob  = ({1'b0, sel} >= NUM_IN_W);

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        bad_sel_d   = bad_sel_q;
        bad_cnt_d   = bad_cnt_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        out_data_d = sel_data;
                        out_sel_d  = sel;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_data_d = sel_data;
                        skid_sel_d  = sel;
                        state_d     = TWO;
                    end else if (!in_xfer && out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        out_data_d = sel_data;
                        out_sel_d  = sel;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (out_xfer) begin
                        out_data_d = skid_data_q;
                        out_sel_d  = skid_sel_q;
                        state_d    = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase

            if (in_xfer && sel_oob) begin
                bad_sel_d = 1'b1;
                if (bad_cnt_q != BAD_CNT_MAX) begin
                    bad_cnt_d = bad_cnt_q + 8'd1;
                end
            end
        end

        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b0;
            bad_sel_q   <= 1'b0;
            bad_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            bad_sel_q   <= bad_sel_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

endmodule
